// File: rtl/seven_seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seven_seg_pkg                                                   |
// | Brief    : Shared 7-segment code table and capture FSM state type.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package seven_seg_pkg;

    // Segment bit order: bit0=a .. bit6=g; the encoder uses the same table.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        HELD   = 1'b1
    } cap_state_t;

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/seven_seg_capture_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seven_seg_capture_if                                            |
// | Brief    : Multiplexed 7-seg bus in, decoded per-digit mirror out.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface seven_seg_capture_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic [4*NUM_DIGITS-1:0] digits_out;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    update;
    logic                    err;

    modport master (
        output seg_in, dig_en,
        input  digits_out, digit_valid, update, err
    );

    modport slave (
        input  seg_in, dig_en,
        output digits_out, digit_valid, update, err
    );
endinterface : seven_seg_capture_if
`default_nettype wire

// File: rtl/seven_seg_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seven_seg_decode                                                |
// | Brief    : Inverse of SEG_HEX: pattern -> {hit, blank, nibble}.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  wire logic [6:0] i_seg,
    output logic            o_hit,
    output logic            o_blank,
    output logic [3:0]      o_nibble
);

    always_comb begin
        o_hit    = 1'b0;
        o_nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (i_seg == SEG_HEX[i]) begin
                o_hit    = 1'b1;
                o_nibble = 4'(i);
            end
        end
    end

    // Dash is treated like blank: a legitimate "no value" display state.
    assign o_blank = (i_seg == SEG_BLANK) || (i_seg == SEG_DASH);

endmodule : seven_seg_decode
`default_nettype wire

// File: rtl/seven_seg_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seven_seg_capture                                               |
// | Brief    : Samples a multiplexed 7-seg bus, filters, decodes per digit.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    seven_seg_capture_if.slave bus
);

    localparam int SW = 7 + NUM_DIGITS;
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] c_cnt_max   = {CW{1'b1}};
    localparam logic [CW-1:0] c_commit_at = CW'(STABLE_CYCLES - 2);

    logic [6:0]              r_seg_s1, r_seg_s2;
    logic [NUM_DIGITS-1:0]   r_dig_s1, r_dig_s2;
    logic [SW-1:0]           r_prev_sample;
    logic [CW-1:0]           r_cnt;
    cap_state_t              r_state;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic                    r_update;
    logic                    r_err;

    logic [6:0]              w_seg;
    logic [SW-1:0]           w_sample;
    logic                    w_same;
    logic                    w_hit;
    logic                    w_blank;
    logic [3:0]              w_nibble;
    logic                    w_onehot;
    logic [IW-1:0]           w_idx;
    logic [3:0]              w_cur_nibble;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_s1 <= '0;
            r_seg_s2 <= '0;
            r_dig_s1 <= '0;
            r_dig_s2 <= '0;
        end else begin
            r_seg_s1 <= bus.seg_in;
            r_seg_s2 <= r_seg_s1;
            r_dig_s1 <= bus.dig_en;
            r_dig_s2 <= r_dig_s1;
        end
    end

    generate
        if (SEG_ACTIVE_LOW) begin : g_seg_inv
            assign w_seg = ~r_seg_s2;
        end else begin : g_seg_pass
            assign w_seg = r_seg_s2;
        end
    endgenerate

    assign w_sample = {r_dig_s2, w_seg};
    assign w_same   = (w_sample == r_prev_sample);

    seven_seg_decode u_decode (
        .i_seg    (w_seg),
        .o_hit    (w_hit),
        .o_blank  (w_blank),
        .o_nibble (w_nibble)
    );

    // Exactly one enable set means a single lit digit; anything else is a gap or ghost.
    always_comb begin
        int n_set;
        n_set = 0;
        w_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_dig_s2[i]) begin
                n_set = n_set + 1;
                w_idx = IW'(i);
            end
        end
        w_onehot = (n_set == 1);
    end

    assign w_cur_nibble = r_digits[4*w_idx +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_sample <= '0;
            r_cnt         <= '0;
            r_state       <= SETTLE;
            r_digits      <= '0;
            r_valid       <= '0;
            r_update      <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_prev_sample <= w_sample;
            r_update      <= 1'b0;
            r_err         <= 1'b0;
            if (!w_same) begin
                r_cnt   <= '0;
                r_state <= SETTLE;
            end else begin
                if (r_cnt != c_cnt_max) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (r_state == SETTLE && r_cnt == c_commit_at) begin
                    r_state <= HELD;
                    if (w_onehot) begin
                        if (w_hit) begin
                            r_digits[4*w_idx +: 4] <= w_nibble;
                            r_valid[w_idx]         <= 1'b1;
                            if (!r_valid[w_idx] || w_cur_nibble != w_nibble) begin
                                r_update <= 1'b1;
                            end
                        end else begin
                            r_valid[w_idx] <= 1'b0;
                            r_update       <= r_valid[w_idx];
                            r_err          <= !w_blank;
                        end
                    end
                end
            end
        end
    end

    assign bus.digits_out  = r_digits;
    assign bus.digit_valid = r_valid;
    assign bus.update      = r_update;
    assign bus.err         = r_err;

endmodule : seven_seg_capture
`default_nettype wire

// File: tb/tb_seven_seg_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seven_seg_capture                                            |
// | Brief    : Directed self-checking bench for seven_seg_capture.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_seven_seg_capture;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   upd_cnt;
    int   err_cnt;

    logic [6:0] c_seg [16];

    seven_seg_capture_if #(.NUM_DIGITS(4)) bus ();

    seven_seg_capture #(
        .NUM_DIGITS     (4),
        .STABLE_CYCLES  (8),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.update) upd_cnt = upd_cnt + 1;
            if (bus.err)    err_cnt = err_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] dig, input logic [6:0] seg);
        @(negedge clk);
        bus.dig_en = dig;
        bus.seg_in = seg;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        upd_cnt = 0;
        err_cnt = 0;
    endtask

    initial begin
        c_seg = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        n_cmp = 0;
        n_bad = 0;
        clr_counts();

        // 1. reset with junk, then digit 0 = '2'
        rst        = 1'b1;
        bus.dig_en = 4'b1111;
        bus.seg_in = 7'h55;
        step(4);
        chk("rst_digits", 32'(bus.digits_out), 32'h0);
        chk("rst_valid",  32'(bus.digit_valid), 32'h0);
        chk("rst_update", 32'(bus.update), 32'h0);
        chk("rst_err",    32'(bus.err), 32'h0);
        @(negedge clk);
        rst        = 1'b0;
        bus.dig_en = 4'b0001;
        bus.seg_in = 7'b1011011;
        clr_counts();
        step(9);
        chk("t1_valid_clk9", 32'(bus.digit_valid[0]), 32'h0);
        step(1);
        chk("t1_valid_clk10", 32'(bus.digit_valid[0]), 32'h1);
        chk("t1_digit_clk10", 32'(bus.digits_out[3:0]), 32'h2);
        chk("t1_update_clk10", 32'(bus.update), 32'h1);
        step(10);
        chk("t1_update_count", 32'(upd_cnt), 32'd1);
        chk("t1_err_count", 32'(err_cnt), 32'd0);

        // 2. scan all codes through all digits, 12-clock dwell
        clr_counts();
        for (int r = 0; r < 16; r++) begin
            for (int d = 0; d < 4; d++) begin
                int v;
                v = (r + d) % 16;
                drive(4'(1 << d), c_seg[v]);
                step(12);
                chk($sformatf("t2_nib_r%0d_d%0d", r, d), 32'(bus.digits_out[4*d +: 4]), 32'(v));
                chk($sformatf("t2_val_r%0d_d%0d", r, d), 32'(bus.digit_valid[d]), 32'h1);
            end
        end
        chk("t2_update_count", 32'(upd_cnt), 32'd64);
        chk("t2_err_count", 32'(err_cnt), 32'd0);
        chk("t2_final_digits", 32'(bus.digits_out), 32'h210F);

        // 3. short glitch on digit 1, then scan gap
        clr_counts();
        drive(4'b0010, 7'b1111111);
        step(5);
        drive(4'b0000, 7'b0000000);
        step(20);
        chk("t3_digit1", 32'(bus.digits_out[7:4]), 32'h0);
        chk("t3_valid1", 32'(bus.digit_valid[1]), 32'h1);
        chk("t3_update_count", 32'(upd_cnt), 32'd0);
        chk("t3_err_count", 32'(err_cnt), 32'd0);

        // 4. digit 2 = A, then an illegal pattern
        drive(4'b0100, 7'h77);
        step(12);
        chk("t4_setup_A", 32'(bus.digits_out[11:8]), 32'hA);
        clr_counts();
        drive(4'b0100, 7'b0000001);
        step(10);
        chk("t4_err_pulse", 32'(bus.err), 32'h1);
        chk("t4_update_pulse", 32'(bus.update), 32'h1);
        chk("t4_valid2", 32'(bus.digit_valid[2]), 32'h0);
        chk("t4_digit2_kept", 32'(bus.digits_out[11:8]), 32'hA);
        step(6);
        chk("t4_err_count", 32'(err_cnt), 32'd1);
        chk("t4_update_count", 32'(upd_cnt), 32'd1);

        // 5. ghost and empty enables, then dash on digit 3
        clr_counts();
        drive(4'b0110, 7'h3F);
        step(16);
        drive(4'b0000, 7'h3F);
        step(16);
        chk("t5_digits", 32'(bus.digits_out), 32'h2A0F);
        chk("t5_valid", 32'(bus.digit_valid), 32'hB);
        chk("t5_update_count", 32'(upd_cnt), 32'd0);
        chk("t5_err_count", 32'(err_cnt), 32'd0);
        drive(4'b1000, 7'b1000000);
        step(14);
        chk("t5_dash_valid3", 32'(bus.digit_valid[3]), 32'h0);
        chk("t5_dash_digit3", 32'(bus.digits_out[15:12]), 32'h2);
        chk("t5_dash_err", 32'(err_cnt), 32'd0);
        chk("t5_dash_update", 32'(upd_cnt), 32'd1);

        // 6. reset mid-settle, then a fresh full settle
        drive(4'b0001, 7'h66);
        step(5);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_digits", 32'(bus.digits_out), 32'h0);
        chk("t6_rst_valid", 32'(bus.digit_valid), 32'h0);
        step(2);
        @(negedge clk);
        rst = 1'b0;
        clr_counts();
        step(9);
        chk("t6_valid_clk9", 32'(bus.digit_valid[0]), 32'h0);
        step(1);
        chk("t6_valid_clk10", 32'(bus.digit_valid[0]), 32'h1);
        chk("t6_digit_clk10", 32'(bus.digits_out[3:0]), 32'h4);
        step(5);
        chk("t6_update_count", 32'(upd_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_seven_seg_capture
`default_nettype wire
